// File: rtl/wrr_packet_arbiter.sv
// rtl/wrr_packet_arbiter.sv - weighted round-robin packet arbiter and stream mux
// A grant is held from the first beat until the last beat is accepted.
module wrr_packet_arbiter #(
  parameter int N            = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 4,
  parameter int INDEX_WIDTH  = (N == 1) ? 1 : $clog2(N)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N*WEIGHT_WIDTH-1:0] i_weight,
  input  logic [N-1:0]              i_valid,
  input  logic [N*DATA_WIDTH-1:0]   i_data,
  input  logic [N-1:0]              i_last,
  output logic [N-1:0]              o_ready,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_last,
  input  logic                      i_ready,
  output logic [INDEX_WIDTH-1:0]    o_grant,
  output logic                      o_busy
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [WEIGHT_WIDTH-1:0] ONE = WEIGHT_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [WEIGHT_WIDTH-1:0] r_credit [N];
  logic [INDEX_WIDTH-1:0]  r_last_grant;
  logic [INDEX_WIDTH-1:0]  r_grant;

  logic [WEIGHT_WIDTH-1:0] w_weight [N];
  logic [DATA_WIDTH-1:0]   w_data [N];
  logic [INDEX_WIDTH-1:0]  w_cand [N];
  logic [N-1:0]            w_eligible;
  logic                    w_found;
  logic [INDEX_WIDTH-1:0]  w_pick;
  logic                    w_busy;
  logic                    w_valid_g;
  logic                    w_last_g;
  logic                    w_accept_last;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_weight[gi]   = i_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign w_data[gi]     = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_eligible[gi] = i_valid[gi] && (r_credit[gi] != '0);
    end
  endgenerate

  // Search order starts one past the previous owner and wraps mod N.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_cand[k] = INDEX_WIDTH'((int'(r_last_grant) + k + 1) % N);
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_eligible[w_cand[k]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[k];
      end
    end
  end

  assign w_busy        = (r_state == S_BUSY);
  assign w_valid_g     = i_valid[r_grant];
  assign w_last_g      = i_last[r_grant];
  assign w_accept_last = w_busy && w_valid_g && i_ready && w_last_g;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_next = S_BUSY;
      S_BUSY:  if (w_accept_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy  = w_busy;
    o_valid = w_busy && w_valid_g;
    o_last  = w_busy && w_last_g;
    o_data  = w_busy ? w_data[r_grant] : '0;
    for (int i = 0; i < N; i++) begin
      o_ready[i] = w_busy && (r_grant == INDEX_WIDTH'(i)) && i_ready;
    end
  end

  // Reload only when someone is waiting but every waiter has run dry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= INDEX_WIDTH'(N - 1);
      r_grant      <= '0;
      for (int i = 0; i < N; i++) begin
        r_credit[i] <= '0;
      end
    end else if (r_state == S_IDLE) begin
      if (w_found) begin
        r_grant <= w_pick;
      end else if (i_valid != '0) begin
        for (int i = 0; i < N; i++) begin
          r_credit[i] <= (w_weight[i] == '0) ? ONE : w_weight[i];
        end
      end
    end else if (w_accept_last) begin
      r_last_grant <= r_grant;
      if (r_credit[r_grant] != '0) begin
        r_credit[r_grant] <= r_credit[r_grant] - ONE;
      end
    end
  end

  assign o_grant = r_grant;

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// tb/tb_wrr_packet_arbiter.sv - randomized scoreboard bench for wrr_packet_arbiter
// A packet-level reference model predicts owner, bubbles and beat order.
module tb_wrr_packet_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int IW = 2;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [N*WW-1:0] i_weight = '0;
  logic [N-1:0]    i_valid = '0;
  logic [N*DW-1:0] i_data = '0;
  logic [N-1:0]    i_last = '0;
  logic [N-1:0]    o_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic            o_last;
  logic            i_ready = 1'b0;
  logic [IW-1:0]   o_grant;
  logic            o_busy;

  wrr_packet_arbiter #(.N(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_weight(i_weight), .i_valid(i_valid),
    .i_data(i_data), .i_last(i_last), .o_ready(o_ready), .o_valid(o_valid),
    .o_data(o_data), .o_last(o_last), .i_ready(i_ready), .o_grant(o_grant),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          owner;
    logic [31:0] data;
    bit          last;
  } beat_t;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  bit       m_busy;
  int       m_owner;
  int       m_last;
  int       m_credit [N];
  bit       exp_busy;
  bit       exp_valid;
  int       exp_owner;
  logic [N-1:0] exp_ready;
  beat_t    exp_q [$];

  bit          p_active [N];
  bit          p_pres [N];
  int          p_len [N];
  int          p_idx [N];
  logic [31:0] p_data [N];

  logic [N-1:0] ph_mask;
  int ph_maxlen, ph_ready_pct, ph_gap_pct, ph_start_pct;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int wt(input int r);
    return int'(i_weight[r*WW +: WW]);
  endfunction

  // Spec rules at packet level: rotate from last owner, credit gating, reload on starvation.
  task automatic model_commit();
    logic [N-1:0] acc;
    acc = '0;
    if (!m_busy) begin
      int pick;
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (pick < 0 && i_valid[c] && m_credit[c] > 0) pick = c;
      end
      if (pick >= 0) begin
        m_busy  = 1'b1;
        m_owner = pick;
      end else if (i_valid != '0) begin
        for (int r = 0; r < N; r++) m_credit[r] = (wt(r) == 0) ? 1 : wt(r);
      end
    end else if (i_valid[m_owner] && i_ready) begin
      acc[m_owner] = 1'b1;
      if (i_last[m_owner]) begin
        m_credit[m_owner]--;
        m_last = m_owner;
        m_busy = 1'b0;
      end
    end
    for (int r = 0; r < N; r++) begin
      if (acc[r]) begin
        p_pres[r] = 1'b0;
        p_idx[r]++;
        if (p_idx[r] == p_len[r]) p_active[r] = 1'b0;
      end
    end
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < N; r++) begin
      if (!p_active[r] && ph_mask[r] && $urandom_range(99, 0) < ph_start_pct) begin
        p_active[r] = 1'b1;
        p_len[r]    = $urandom_range(ph_maxlen, 1);
        p_idx[r]    = 0;
        p_pres[r]   = 1'b0;
      end
      if (p_active[r] && !p_pres[r] && $urandom_range(99, 0) >= ph_gap_pct) begin
        p_pres[r] = 1'b1;
        p_data[r] = $urandom;
      end
      i_valid[r]          = p_pres[r];
      i_data[r*DW +: DW]  = p_data[r];
      i_last[r]           = p_pres[r] && (p_idx[r] == p_len[r] - 1);
    end
    i_ready = ($urandom_range(99, 0) < ph_ready_pct);
  endtask

  task automatic model_predict();
    beat_t b;
    exp_busy  = m_busy;
    exp_owner = m_owner;
    exp_valid = m_busy && i_valid[m_owner];
    exp_ready = '0;
    if (m_busy && i_ready) exp_ready[m_owner] = 1'b1;
    if (exp_valid && i_ready) begin
      b.owner = m_owner;
      b.data  = p_data[m_owner];
      b.last  = i_last[m_owner];
      exp_q.push_back(b);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    model_commit();
    #1;
    drive_inputs();
    model_predict();
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    i_rst_n = 1'b0;
    i_valid = '0;
    i_last  = '0;
    i_data  = '0;
    i_ready = 1'b0;
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    for (int r = 0; r < N; r++) begin
      m_credit[r] = 0;
      p_active[r] = 1'b0;
      p_pres[r]   = 1'b0;
      p_idx[r]    = 0;
      p_len[r]    = 0;
      p_data[r]   = '0;
    end
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_valid", o_valid, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_ready", o_ready, 0);
    chk("reset_last", o_last, 0);
    chk("reset_grant", o_grant, 0);
    i_rst_n = 1'b1;
    model_predict();
    mon_en = 1'b1;
  endtask

  task automatic set_phase(input logic [N-1:0] mask, input int maxlen, input int rdy,
                           input int gap, input int start);
    ph_mask = mask; ph_maxlen = maxlen; ph_ready_pct = rdy;
    ph_gap_pct = gap; ph_start_pct = start;
  endtask

  always @(negedge i_clk) begin
    if (mon_en) begin
      beat_t b;
      chk("busy", o_busy, exp_busy);
      chk("valid", o_valid, exp_valid);
      chk("ready", o_ready, exp_ready);
      if (exp_busy) chk("grant", o_grant, exp_owner);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          b = exp_q.pop_front();
          chk("beat_owner", o_grant, b.owner);
          chk("beat_data", o_data, b.data);
          chk("beat_last", o_last, b.last);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int budget;
    bit t1_busy [5];
    int t1_grant [5];
    t1_busy  = '{0, 0, 1, 0, 1};
    t1_grant = '{0, 0, 0, 0, 2};

    set_phase(4'b0101, 1, 100, 0, 100);
    i_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    do_reset();
    // Reload bubble, select cycle, then 0, idle gap, then 2.
    for (int s = 0; s < 5; s++) begin
      step();
      chk("t1_busy", o_busy, t1_busy[s]);
      if (t1_busy[s]) chk("t1_grant", o_grant, t1_grant[s]);
    end
    repeat (35) step();

    i_weight = {4'd1, 4'd1, 4'd1, 4'd2};
    set_phase(4'b0011, 1, 100, 0, 100);
    repeat (60) step();

    i_weight = {4'd1, 4'd1, 4'd3, 4'd2};
    set_phase(4'b0011, 4, 50, 0, 100);
    repeat (200) step();

    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < N; r++) i_weight[r*WW +: WW] = 4'($urandom_range(3, 0));
      set_phase(4'b1111, 4, 70, 40, 60);
      repeat (200) step();
    end

    i_weight = {4'd0, 4'd2, 4'd2, 4'd2};
    set_phase(4'b1000, 2, 80, 20, 100);
    repeat (60) step();

    i_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    set_phase(4'b1111, 4, 30, 0, 100);
    budget = 0;
    while (!(m_busy && p_idx[m_owner] > 0) && budget < 500) begin
      step();
      budget++;
    end
    chk("midpacket_reached", budget < 500, 1);
    #2;
    mon_en  = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", o_valid, 0);
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_ready", o_ready, 0);
    do_reset();

    set_phase(4'b1111, 1, 100, 0, 100);
    budget = 0;
    while (!m_busy && budget < 10) begin
      step();
      budget++;
    end
    chk("post_reset_busy_reached", budget < 10, 1);
    chk("post_reset_grant", o_grant, 0);
    repeat (60) step();

    set_phase(4'b0000, 1, 100, 0, 0);
    budget = 0;
    while ((exp_q.size() != 0 || m_busy || p_active[0] || p_active[1] ||
            p_active[2] || p_active[3]) && budget < 500) begin
      step();
      budget++;
    end
    step();
    chk("drain_done", budget < 500, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
